tdc_coarse_stamper: RTL and testbench
=====================================

# tdc_coarse_stamper

Captures a coarse timestamp on every qualified rising edge of the synchronized hit signal. It latches a free-running coarse counter into a small first-word-fall-through FIFO and presents the stamps on a valid/ready stream. It sits directly downstream of the hit synchronizer in the `clk_input` domain and feeds the readout/fine-time merge logic. It also provides hold-off (dead time), rollover signalling and drop accounting.

## Interface
- `COUNTER_WIDTH`, 32: coarse counter and stamp width.
- `FIFO_DEPTH`, 8: stamp buffer entries. Must be a power of two, ≥2.
- `HOLDOFF_CYCLES`, 4: dead time after a hit, in cycles. 0 disables hold-off.
- `clk_input` input 1: clock.
- `reset` input 1: reset, asynchronous, active-high.
- `enable` input 1: hit capture enable.
- `counter_clear` input 1: synchronous clear of the coarse counter.
- `event_sync` input 1: synchronized hit level from the synchronizer.
- `ts_data` output COUNTER_WIDTH: head-of-FIFO stamp.
- `ts_valid` output 1: FIFO not empty.
- `ts_ready` input 1: consumer accepts `ts_data`.
- `rollover` output 1: one-cycle pulse when the counter wraps.
- `fifo_level` output $clog2(FIFO_DEPTH+1): current number of entries.
- `dropped_count` output 16: hits lost to a full FIFO, saturating.

## Operation
- **Coarse counter**
  - Increments every cycle and wraps modulo 2^COUNTER_WIDTH.
  - `counter_clear` loads 0 instead of incrementing.
  - `rollover` pulses on the all-ones→0 wrap only, never on a clear.
- **Edge detect**
  - `prev` is a register of `event_sync`. A hit is `event_sync & ~prev`.
  - `prev` resets to 1, so a level that is already high when reset releases is not a hit.
- **Qualification**
  - A hit is qualified only if `enable`=1 and the FSM is in ARMED.
  - `prev` tracks `event_sync` regardless of `enable` or FSM state. A level held high never retriggers.
- **FSM**
  - ARMED: a qualified hit moves to HOLDOFF (or stays ARMED if HOLDOFF_CYCLES=0).
  - HOLDOFF: a down-counter is loaded with HOLDOFF_CYCLES-1. Return to ARMED when the counter reaches 0.
  - Hits in HOLDOFF are ignored and do not count as dropped.
  - `enable` low does not abort HOLDOFF.
- **Capture**
  - A qualified hit pushes the counter register value from that cycle, i.e. the pre-increment/pre-clear value, into the FIFO.
- **FIFO**
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - Otherwise the stamp is discarded, `dropped_count` increments (saturating at 0xFFFF), and the FSM still enters HOLDOFF.
  - Pop occurs when `ts_valid & ts_ready`.
  - `ts_data` and `ts_valid` are stable until popped.
  - `ts_ready` while empty has no effect.
  - Simultaneous push and pop leaves `fifo_level` unchanged.
- **Reset**
  - Asynchronous.
  - `ts_valid`=0, `ts_data`=0, `fifo_level`=0, `rollover`=0, `dropped_count`=0.
  - Counter=0, FSM=ARMED, `prev`=1.
  - Mid-operation reset discards all buffered stamps and any hold-off in progress.

## Timing
- **Hit to stamp:** if `event_sync` is first sampled high at clock edge N with the counter equal to C, the stamp C is written at edge N. With the FIFO previously empty, `ts_valid`=1 and `ts_data`=C after edge N (1 cycle).
- **Hit rate:** the minimum spacing of recorded hits is HOLDOFF_CYCLES+1 cycles. With HOLDOFF_CYCLES=0 the limit is 2 cycles, set by edge detection.
- **Clear vs. hit:** `counter_clear` and a hit in the same cycle store the pre-clear value. The counter reads 0 in the following cycle.
- **Wrap:** `rollover` is high for the single cycle in which the counter register equals 0 following the all-ones value.
- **Outputs:** `fifo_level` and `dropped_count` are registered and update at the same edge as the push/pop.
- **Backpressure:** `ts_ready` has no combinational path to `ts_valid`.

## Test plan
- **Reset release and single hit:** release reset with `event_sync`=1, then 0, then rise when the counter is 10. Required: no stamp for the initial level; one stamp of 10; `ts_valid` one cycle after the rise.
- **Hold-off:** HOLDOFF_CYCLES=4, pulses rising at counter 20, 22 and 26. Required: stamps 20 and 26 only; `dropped_count`=0.
- **FIFO full:** `ts_ready`=0, 9 hits spaced 6 cycles apart. Required: `fifo_level`=8, `dropped_count`=1. Then `ts_ready`=1 drains 8 stamps in order, one per cycle, and `ts_valid` falls after the 8th.
- **Full with simultaneous pop:** FIFO at 8 entries, hit and pop in the same cycle. Required: push accepted, `fifo_level` stays 8, `dropped_count` unchanged.
- **Clear and rollover:** COUNTER_WIDTH=8, hit coinciding with `counter_clear` at count 100. Required: stamp 100 and counter 0 next cycle. Free-running: `rollover` pulses once per 256 cycles, at count 0, and never on a clear.
- **Reset mid-operation:** assert `reset` with 3 entries buffered and FSM in HOLDOFF. Required: `ts_valid`=0 and `fifo_level`=0 immediately; a new rising hit after release is stamped normally.

Source files
------------

// File: rtl/tdc_coarse_stamper_if.sv
// Timestamp stream between the coarse stamper and its consumer.
//   ts_data  : head-of-FIFO coarse stamp (COUNTER_WIDTH bits)
//   ts_valid : a stamp is presented on ts_data
//   ts_ready : consumer takes ts_data when ts_valid is also high
// The master modport is the stamper and the slave modport is the readout side.
interface tdc_coarse_stamper_if #(
  parameter int COUNTER_WIDTH = 32
);
  logic [COUNTER_WIDTH-1:0] ts_data;
  logic                     ts_valid;
  logic                     ts_ready;

  modport master (output ts_data, output ts_valid, input ts_ready);
  modport slave  (input ts_data, input ts_valid, output ts_ready);
endinterface

// File: rtl/tdc_coarse_stamper.sv
// Coarse timestamp capture for the synchronized hit signal (clk_input domain).
// A free-running coarse counter is latched on every qualified rising edge of
// event_sync into a first-word-fall-through FIFO. The FIFO is read out over a
// valid/ready stream. A hold-off window follows each recorded hit.
// Ports:
//   clk_input, reset (async, active-high)
//   enable        : hit capture enable
//   counter_clear : synchronous clear of the coarse counter
//   event_sync    : synchronized hit level
//   ts_if         : stamp stream (master side: ts_data, ts_valid out; ts_ready in)
//   rollover      : one-cycle pulse while the counter reads 0 after all-ones
//   fifo_level    : buffered stamp count
//   dropped_count : hits lost to a full FIFO, saturating at 0xFFFF
module tdc_coarse_stamper #(
  parameter int COUNTER_WIDTH  = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic                               clk_input,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               counter_clear,
  input  logic                               event_sync,
  tdc_coarse_stamper_if.master               ts_if,
  output logic                               rollover,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic [15:0]                        dropped_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);

  typedef enum logic [0:0] {
    ST_ARMED   = 1'b0,
    ST_HOLDOFF = 1'b1
  } state_t;

  logic [COUNTER_WIDTH-1:0] counter_r;
  logic                     rollover_r;
  logic                     prev_r;
  state_t                   state_r, state_s;
  logic [HW-1:0]            hold_cnt_r, hold_cnt_s;
  logic [COUNTER_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_r, rd_ptr_r, rd_next_s;
  logic [LW-1:0]            level_r, level_s;
  logic [COUNTER_WIDTH-1:0] head_r, head_s;
  logic                     valid_r;
  logic [15:0]              drop_cnt_r;

  logic hit_s, qualified_s, pop_s, push_s, drop_s;

  // Edge detection and push/pop qualification.
  assign hit_s       = event_sync & ~prev_r;
  assign qualified_s = hit_s & enable & (state_r == ST_ARMED);
  assign pop_s       = valid_r & ts_if.ts_ready;
  // A full FIFO still accepts the push when the head leaves in the same cycle.
  assign push_s      = qualified_s & ((level_r != FULL_LEVEL) | pop_s);
  assign drop_s      = qualified_s & ~push_s;
  assign rd_next_s   = rd_ptr_r + AW'(1);

  assign ts_if.ts_data  = head_r;
  assign ts_if.ts_valid = valid_r;
  assign rollover       = rollover_r;
  assign fifo_level     = level_r;
  assign dropped_count  = drop_cnt_r;

  // Coarse counter, wrap pulse and previous hit level.
  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      counter_r  <= '0;
      rollover_r <= 1'b0;
      prev_r     <= 1'b1;
    end else begin
      if (counter_clear) begin
        counter_r <= '0;
      end else begin
        counter_r <= counter_r + COUNTER_WIDTH'(1);
      end
      // Registered so the pulse lines up with the cycle the counter reads 0.
      rollover_r <= ~counter_clear & (counter_r == {COUNTER_WIDTH{1'b1}});
      prev_r     <= event_sync;
    end
  end

  // Hold-off FSM next state.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    case (state_r)
      ST_ARMED: begin
        if (qualified_s && (HOLDOFF_CYCLES > 0)) begin
          state_s    = ST_HOLDOFF;
          hold_cnt_s = HOLD_LOAD;
        end else begin
          state_s    = ST_ARMED;
        end
      end
      ST_HOLDOFF: begin
        if (hold_cnt_r == '0) begin
          state_s    = ST_ARMED;
        end else begin
          hold_cnt_s = hold_cnt_r - HW'(1);
        end
      end
      default: begin
        state_s    = ST_ARMED;
        hold_cnt_s = '0;
      end
    endcase
  end

  // Hold-off FSM state register.
  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      state_r    <= ST_ARMED;
      hold_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
    end
  end

  // Next head-of-FIFO value and occupancy.
  always_comb begin
    head_s = head_r;
    if (pop_s) begin
      if (level_r > LW'(1)) begin
        // Entry behind the head was written in an earlier cycle.
        head_s = mem_r[rd_next_s];
      end else if (push_s) begin
        head_s = counter_r;
      end else begin
        head_s = head_r;
      end
    end else if (push_s && (level_r == '0)) begin
      head_s = counter_r;
    end else begin
      head_s = head_r;
    end

    case ({push_s, pop_s})
      2'b10:   level_s = level_r + LW'(1);
      2'b01:   level_s = level_r - LW'(1);
      default: level_s = level_r;
    endcase
  end

  // Stamp storage; contents become meaningless once the pointers reset.
  always_ff @(posedge clk_input) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= counter_r;
    end
  end

  // FIFO pointers, registered stream outputs and drop accounting.
  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      head_r     <= '0;
      valid_r    <= 1'b0;
      drop_cnt_r <= 16'h0000;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_next_s;
      end
      level_r <= level_s;
      head_r  <= head_s;
      valid_r <= (level_s != '0);
      if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_tdc_coarse_stamper.sv
module tb_tdc_coarse_stamper;

  localparam int CW    = 8;
  localparam int DEPTH = 8;
  localparam int HOLD  = 4;

  logic        clk_input = 1'b0;
  logic        reset;
  logic        enable;
  logic        counter_clear;
  logic        event_sync;
  logic        rollover;
  logic [3:0]  fifo_level;
  logic [15:0] dropped_count;

  tdc_coarse_stamper_if #(.COUNTER_WIDTH(CW)) ts_if ();

  tdc_coarse_stamper #(
    .COUNTER_WIDTH  (CW),
    .FIFO_DEPTH     (DEPTH),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .clk_input     (clk_input),
    .reset         (reset),
    .enable        (enable),
    .counter_clear (counter_clear),
    .event_sync    (event_sync),
    .ts_if         (ts_if),
    .rollover      (rollover),
    .fifo_level    (fifo_level),
    .dropped_count (dropped_count)
  );

  always #5 clk_input = ~clk_input;

  typedef struct {
    int reps;
    bit ev;
    bit en;
    bit rdy;
    bit clr;
    bit x_valid;
    int x_data;
    int x_level;
    int x_drop;
  } vec_t;

  vec_t vecs[$];
  int   e = 0;          // edges described by the table so far (= counter value sampled at next edge)
  int   n_applied = 0;
  int   n_fail = 0;

  function automatic void add(input int reps, input bit ev, input bit en, input bit rdy,
                              input bit clr, input bit xv, input int xd, input int xl,
                              input int xdrop);
    vec_t v;
    v.reps = reps; v.ev = ev; v.en = en; v.rdy = rdy; v.clr = clr;
    v.x_valid = xv; v.x_data = xd; v.x_level = xl; v.x_drop = xdrop;
    vecs.push_back(v);
    e += reps;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_applied++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_out(input string name, input bit xv, input int xd, input int xl,
                           input int xdrop);
    check({name, " valid"}, {31'd0, ts_if.ts_valid}, xv);
    if (xv) check({name, " data"}, {24'd0, ts_if.ts_data}, xd);
    check({name, " level"}, {28'd0, fifo_level}, xl);
    check({name, " dropped"}, {16'd0, dropped_count}, xdrop);
  endtask

  // One or more clock edges with fixed inputs; outputs settle 1 time unit after the edge.
  task automatic step(input bit ev, input bit en, input bit rdy, input bit clr, input int n);
    for (int i = 0; i < n; i++) begin
      event_sync     = ev;
      enable         = en;
      ts_if.ts_ready = rdy;
      counter_clear  = clr;
      @(posedge clk_input);
      #1;
    end
  endtask

  initial begin
    int s[9];
    int ro;

    reset          = 1'b0;
    enable         = 1'b1;
    counter_clear  = 1'b0;
    event_sync     = 1'b1;
    ts_if.ts_ready = 1'b0;
    #2 reset = 1'b1;
    #2;
    check_out("reset", 1'b0, 0, 0, 0);
    check("reset data", {24'd0, ts_if.ts_data}, 0);
    check("reset rollover", {31'd0, rollover}, 0);
    @(posedge clk_input);
    @(posedge clk_input);
    #1 reset = 1'b0;

    // ---------------- table: reset release, single hit, hold-off, enable
    add(1, 1, 1, 0, 0, 0, 0, 0, 0);        // level high at release: no hit
    add(9, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1, 10, 1, 0);       // rise sampled with counter 10
    add(1, 0, 1, 1, 0, 0, 0, 0, 0);        // pop
    add(8, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1, 20, 1, 0);       // rise at 20
    add(1, 0, 1, 0, 0, 1, 20, 1, 0);
    add(1, 1, 1, 0, 0, 1, 20, 1, 0);       // rise at 22: in hold-off
    add(3, 0, 1, 0, 0, 1, 20, 1, 0);
    add(1, 1, 1, 0, 0, 1, 20, 2, 0);       // rise at 26
    add(1, 0, 1, 1, 0, 1, 26, 1, 0);
    add(1, 0, 1, 1, 0, 0, 0, 0, 0);
    add(5, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);        // rise with enable low
    add(2, 1, 1, 0, 0, 0, 0, 0, 0);        // held level never retriggers
    add(1, 0, 1, 0, 0, 0, 0, 0, 0);
    // FIFO full: 9 hits spaced 6 cycles, ready low
    for (int i = 0; i < 9; i++) begin
      add(5, 0, 1, 0, 0, (i > 0), s[0], i, 0);
      s[i] = e;
      add(1, 1, 1, 0, 0, 1'b1, s[0], (i + 1 > 8) ? 8 : i + 1, (i == 8) ? 1 : 0);
    end
    for (int k = 1; k <= 8; k++) begin
      add(1, 0, 1, 1, 0, (k < 8), (k < 8) ? s[k] : 0, 8 - k, 1);
    end

    for (int v = 0; v < vecs.size(); v++) begin
      step(vecs[v].ev, vecs[v].en, vecs[v].rdy, vecs[v].clr, vecs[v].reps);
      check_out($sformatf("vec%0d", v), vecs[v].x_valid, vecs[v].x_data,
                vecs[v].x_level, vecs[v].x_drop);
    end

    // ---------------- full FIFO with simultaneous push and pop
    step(0, 1, 0, 1, 1);                   // counter -> 0
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0, 5);
      step(1, 1, 0, 0, 1);                 // stamps 5, 11, ..., 47
    end
    check_out("full8", 1'b1, 5, 8, 1);
    step(0, 1, 0, 0, 5);
    step(1, 1, 1, 0, 1);                   // hit at 53 with pop
    check_out("push+pop full", 1'b1, 11, 8, 1);
    step(0, 1, 1, 0, 6);
    check_out("drain6", 1'b1, 47, 2, 1);
    step(0, 1, 1, 0, 1);
    check_out("last stamp", 1'b1, 53, 1, 1);
    step(0, 1, 1, 0, 1);
    check_out("drained", 1'b0, 0, 0, 1);

    // ---------------- clear coinciding with a hit
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 0, 100);
    step(1, 1, 0, 1, 1);                   // hit + clear at 100
    check_out("clear+hit", 1'b1, 100, 1, 1);
    check("clear no rollover", {31'd0, rollover}, 0);
    step(0, 1, 1, 0, 5);                   // counter restarted at 0
    step(1, 1, 0, 0, 1);
    check_out("after clear", 1'b1, 5, 1, 1);
    step(0, 1, 1, 0, 1);

    // ---------------- free-running rollover
    step(0, 1, 0, 1, 1);
    check("rollover after clear", {31'd0, rollover}, 0);
    ro = 0;
    for (int i = 0; i < 255; i++) begin
      step(0, 1, 0, 0, 1);
      if (rollover) ro++;
    end
    check("rollover early", ro, 0);
    step(0, 1, 0, 0, 1);
    check("rollover at wrap", {31'd0, rollover}, 1);
    step(0, 1, 0, 0, 1);
    check("rollover one cycle", {31'd0, rollover}, 0);
    ro = 0;
    for (int i = 0; i < 254; i++) begin
      step(0, 1, 0, 0, 1);
      if (rollover) ro++;
    end
    check("rollover second window", ro, 0);
    step(0, 1, 0, 1, 1);                   // clear while all-ones
    check("rollover on clear at max", {31'd0, rollover}, 0);

    // ---------------- reset mid-operation
    step(0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 5);
      step(1, 1, 0, 0, 1);
    end
    check_out("3 buffered", 1'b1, 5, 3, 1);
    reset = 1'b1;
    #2;
    check_out("mid reset", 1'b0, 0, 0, 0);
    check("mid reset data", {24'd0, ts_if.ts_data}, 0);
    event_sync = 1'b0;
    @(posedge clk_input);
    @(posedge clk_input);
    #1 reset = 1'b0;
    step(0, 1, 0, 0, 2);
    step(1, 1, 0, 0, 1);
    check_out("hit after reset", 1'b1, 2, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule
